move_arbiter: RTL and testbench

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/move_arbiter.sv | 144 ++++++++++++++
 tb/tb_move_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/move_arbiter.sv
// Tic-tac-toe move arbiter: validates human/AI moves, keeps both boards, detects win/tie.
// Optional per-turn forfeit timer is built only when TURN_TIMEOUT_EN is defined.
module move_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_mode,
    input  logic [8:0] btn,
    input  logic [8:0] ai_move,
    input  logic       ai_valid,
    output logic       ai_req,
    output logic [8:0] p1_cells,
    output logic [8:0] p2_cells,
    output logic       p1_turn,
    output logic       p2_turn,
    output logic       p1_win,
    output logic       p2_win,
    output logic       tie,
    output logic       move_err,
    output logic       timeout
);

    typedef enum logic [2:0] {
        P1_TURN,
        P2_TURN,
        CHECK,
        P1_WIN,
        P2_WIN,
        TIE
    } state_t;

    state_t     state, state_next;
    logic [8:0] btn_prev;
    logic [8:0] btn_edge;
    logic [8:0] move_vec;
    logic [8:0] occupied;
    logic [8:0] mover_cells;
    logic       last_p2;
    logic       in_turn;
    logic       accept;
    logic       reject;
    logic       has_line;
    logic       expire;

    function automatic logic line_done(input logic [8:0] c);
        return (&c[2:0]) || (&c[5:3]) || (&c[8:6]) ||
               (c[0] && c[3] && c[6]) || (c[1] && c[4] && c[7]) ||
               (c[2] && c[5] && c[8]) || (c[0] && c[4] && c[8]) ||
               (c[2] && c[4] && c[6]);
    endfunction

    always_comb begin
        btn_edge    = btn & ~btn_prev;
        occupied    = p1_cells | p2_cells;
        mover_cells = last_p2 ? p2_cells : p1_cells;
        has_line    = line_done(mover_cells);
        in_turn     = (state == P1_TURN) || (state == P2_TURN);
        move_vec    = '0;
        case (state)
            P1_TURN: move_vec = btn_edge;
            P2_TURN: move_vec = game_mode ? (ai_valid ? ai_move : '0) : btn_edge;
            default: move_vec = '0;
        endcase
        accept = $onehot(move_vec) && ((move_vec & occupied) == '0);
        reject = (move_vec != '0) && !accept;
    end

    always_comb begin
        state_next = state;
        case (state)
            P1_TURN: begin
                if (accept)      state_next = CHECK;
                else if (expire) state_next = P2_TURN;
            end
            P2_TURN: begin
                if (accept)      state_next = CHECK;
                else if (expire) state_next = P1_TURN;
            end
            CHECK: begin
                // A completed line outranks a full board on the ninth move.
                if (has_line)             state_next = last_p2 ? P2_WIN : P1_WIN;
                else if (occupied == '1)  state_next = TIE;
                else                      state_next = last_p2 ? P1_TURN : P2_TURN;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= P1_TURN;
            p1_cells <= '0;
            p2_cells <= '0;
            last_p2  <= 1'b0;
            move_err <= 1'b0;
            btn_prev <= '1;
        end else begin
            state    <= state_next;
            move_err <= reject;
            btn_prev <= btn;
            if (accept) begin
                if (state == P2_TURN) begin
                    p2_cells <= p2_cells | move_vec;
                    last_p2  <= 1'b1;
                end else begin
                    p1_cells <= p1_cells | move_vec;
                    last_p2  <= 1'b0;
                end
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    logic [15:0] turn_cnt;

    assign expire = in_turn && !accept && (turn_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            turn_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (state_next != state || !in_turn) turn_cnt <= '0;
            else                                 turn_cnt <= turn_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ in_turn;
    assign expire             = 1'b0;
    assign timeout            = 1'b0;
`endif

    assign p1_turn = (state == P1_TURN);
    assign p2_turn = (state == P2_TURN);
    assign p1_win  = (state == P1_WIN);
    assign p2_win  = (state == P2_WIN);
    assign tie     = (state == TIE);
    assign ai_req  = (state == P2_TURN) && game_mode;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: vector table plus hand sequences for tie/ninth-move win and the turn timer.
module tb_move_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_mode = 1'b0;
    logic [8:0] btn = '0;
    logic [8:0] ai_move = '0;
    logic       ai_valid = 1'b0;
    logic       ai_req, p1_turn, p2_turn, p1_win, p2_win, tie, move_err, timeout;
    logic [8:0] p1_cells, p2_cells;

    int unsigned checks = 0;
    int unsigned failures = 0;

    move_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .reset(reset), .game_mode(game_mode), .btn(btn),
        .ai_move(ai_move), .ai_valid(ai_valid), .ai_req(ai_req),
        .p1_cells(p1_cells), .p2_cells(p2_cells), .p1_turn(p1_turn), .p2_turn(p2_turn),
        .p1_win(p1_win), .p2_win(p2_win), .tie(tie), .move_err(move_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // status byte: {p1_turn, p2_turn, p1_win, p2_win, tie, move_err, timeout, ai_req}
    localparam logic [7:0] S_CHK = 8'h00, S_P1T = 8'h80, S_P2T = 8'h40, S_P1W = 8'h20;
    localparam logic [7:0] S_TIE = 8'h08, S_ERR = 8'h04, S_TO  = 8'h02, S_AI  = 8'h01;

    logic [25:0] outs;
    assign outs = {p1_cells, p2_cells, p1_turn, p2_turn, p1_win, p2_win, tie, move_err, timeout, ai_req};

    typedef struct {
        logic        rst;
        logic        gm;
        logic [8:0]  b;
        logic        aiv;
        logic [8:0]  aim;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic gm, input logic [8:0] b,
                                input logic aiv, input logic [8:0] aim,
                                input logic [8:0] p1, input logic [8:0] p2, input logic [7:0] st);
        vec_t v;
        v.rst = rst; v.gm = gm; v.b = b; v.aiv = aiv; v.aim = aim;
        v.exp = {p1, p2, st};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [25:0] exp);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("FAIL %s: got p1=%h p2=%h st=%b, expected p1=%h p2=%h st=%b",
                     name, outs[25:17], outs[16:8], outs[7:0], exp[25:17], exp[16:8], exp[7:0]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; btn = '0; ai_valid = 1'b0; game_mode = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic press(input logic [8:0] b);
        btn = b;
        step();
        btn = '0;
        step();
    endtask

    initial begin
        // REQ-035 style game, then an occupied-cell and a multi-bit error, then AI turns
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h000,9'h000, S_P1T));
        vecs.push_back(mk(0,0,9'h001,0,9'h000, 9'h001,9'h000, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h000, S_P2T));
        vecs.push_back(mk(0,0,9'h008,0,9'h000, 9'h001,9'h008, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h008, S_P1T));
        vecs.push_back(mk(0,0,9'h002,0,9'h000, 9'h003,9'h008, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h003,9'h008, S_P2T));
        vecs.push_back(mk(0,0,9'h010,0,9'h000, 9'h003,9'h018, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h003,9'h018, S_P1T));
        vecs.push_back(mk(0,0,9'h004,0,9'h000, 9'h007,9'h018, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h007,9'h018, S_P1W));
        vecs.push_back(mk(0,0,9'h100,0,9'h000, 9'h007,9'h018, S_P1W));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h007,9'h018, S_P1W));
        vecs.push_back(mk(1,0,9'h100,0,9'h000, 9'h000,9'h000, S_P1T));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h000,9'h000, S_P1T));
        vecs.push_back(mk(0,0,9'h001,0,9'h000, 9'h001,9'h000, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h000, S_P2T));
        vecs.push_back(mk(0,0,9'h001,0,9'h000, 9'h001,9'h000, S_P2T | S_ERR));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h000, S_P2T));
        vecs.push_back(mk(0,0,9'h002,0,9'h000, 9'h001,9'h002, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h002, S_P1T));
        vecs.push_back(mk(0,0,9'h00C,0,9'h000, 9'h001,9'h002, S_P1T | S_ERR));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h001,9'h002, S_P1T));
        vecs.push_back(mk(1,1,9'h000,0,9'h000, 9'h000,9'h000, S_P1T));
        vecs.push_back(mk(0,1,9'h000,0,9'h000, 9'h000,9'h000, S_P1T));
        vecs.push_back(mk(0,1,9'h001,0,9'h000, 9'h001,9'h000, S_CHK));
        vecs.push_back(mk(0,1,9'h000,0,9'h000, 9'h001,9'h000, S_P2T | S_AI));
        vecs.push_back(mk(0,1,9'h002,0,9'h000, 9'h001,9'h000, S_P2T | S_AI));
        vecs.push_back(mk(0,1,9'h000,1,9'h010, 9'h001,9'h010, S_CHK));
        vecs.push_back(mk(0,1,9'h000,0,9'h000, 9'h001,9'h010, S_P1T));
        vecs.push_back(mk(0,1,9'h000,1,9'h020, 9'h001,9'h010, S_P1T));
        vecs.push_back(mk(0,0,9'h002,0,9'h000, 9'h003,9'h010, S_CHK));
        vecs.push_back(mk(0,0,9'h000,0,9'h000, 9'h003,9'h010, S_P2T));
        vecs.push_back(mk(0,0,9'h000,1,9'h004, 9'h003,9'h010, S_P2T));
        vecs.push_back(mk(0,1,9'h000,1,9'h030, 9'h003,9'h010, S_P2T | S_AI | S_ERR));
        vecs.push_back(mk(0,1,9'h000,0,9'h000, 9'h003,9'h010, S_P2T | S_AI));
        vecs.push_back(mk(0,1,9'h000,1,9'h001, 9'h003,9'h010, S_P2T | S_AI | S_ERR));
        vecs.push_back(mk(0,1,9'h000,0,9'h000, 9'h003,9'h010, S_P2T | S_AI));

        do_reset();
        check("reset_state", {9'h000, 9'h000, S_P1T});

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; game_mode = vecs[i].gm; btn = vecs[i].b;
            ai_valid = vecs[i].aiv; ai_move = vecs[i].aim;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        reset = 1'b0; ai_valid = 1'b0; ai_move = '0; btn = '0;

        // full board without a line: a,b,c,e,d,f,h,g,i
        do_reset();
        step();
        press(9'h001); press(9'h002); press(9'h004); press(9'h010);
        press(9'h008); press(9'h020); press(9'h080); press(9'h040);
        check("tie_before_ninth", {9'h08D, 9'h072, S_P1T});
        press(9'h100);
        check("tie_final", {9'h18D, 9'h072, S_TIE});

        // ninth move fills the board and completes column a-d-g
        do_reset();
        step();
        press(9'h001); press(9'h002); press(9'h004); press(9'h010);
        press(9'h008); press(9'h020); press(9'h080); press(9'h100);
        press(9'h040);
        check("ninth_move_win", {9'h0CD, 9'h132, S_P1W});

        // button held through reset must not count as a press
        reset = 1'b1; btn = 9'h001;
        step();
        reset = 1'b0;
        step(); step();
        check("held_through_reset", {9'h000, 9'h000, S_P1T});
        btn = '0;
        step();

`ifdef TURN_TIMEOUT_EN
        do_reset();
        repeat (7) step();
        check("to_before_limit", {9'h000, 9'h000, S_P1T});
        step();
        check("to_pulse", {9'h000, 9'h000, S_P2T | S_TO});
        step();
        check("to_single_pulse", {9'h000, 9'h000, S_P2T});
        press(9'h001);
        check("to_after_move", {9'h000, 9'h001, S_P1T});
        repeat (3) step();
        do_reset();
        check("to_reset_mid_turn", {9'h000, 9'h000, S_P1T});
        repeat (7) step();
        check("to_cleared_count", {9'h000, 9'h000, S_P1T});
        step();
        check("to_pulse_again", {9'h000, 9'h000, S_P2T | S_TO});
`else
        do_reset();
        repeat (20) step();
        check("no_timeout_idle", {9'h000, 9'h000, S_P1T});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
